// File: rtl/ddr_refresh_pkg.sv
// rtl/ddr_refresh_pkg.sv - shared constants and sizing helpers for the DDR refresh scheduler
package ddr_refresh_pkg;

  localparam int NEED_THRESH_DEF = 8;
  localparam int PEND_WIDTH_DEF  = 5;
  localparam int PEND_SAT_DEF    = (1 << PEND_WIDTH_DEF) - 1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int pend_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/ddr_refresh_sched_if.sv
// rtl/ddr_refresh_sched_if.sv - scheduler <-> command sequencer signal bundle
interface ddr_refresh_sched_if #(
  parameter int NUM_RANKS    = 2,
  parameter int PERIOD_WIDTH = 10
);
  import ddr_refresh_pkg::*;

  localparam int RW = idx_width(NUM_RANKS);

  logic [PERIOD_WIDTH-1:0] refresh_period;
  logic                    set;
  logic [NUM_RANKS-1:0]    rank_en;
  logic                    idle;
  logic [NUM_RANKS-1:0]    grant;
  logic [NUM_RANKS-1:0]    want;
  logic [NUM_RANKS-1:0]    need;
  logic                    sel_valid;
  logic [RW-1:0]           sel_rank;
  logic [NUM_RANKS-1:0]    overflow;

  modport master (
    output refresh_period, set, rank_en, idle, grant,
    input  want, need, sel_valid, sel_rank, overflow
  );

  modport slave (
    input  refresh_period, set, rank_en, idle, grant,
    output want, need, sel_valid, sel_rank, overflow
  );

endinterface

// File: rtl/ddr_refresh_rank.sv
// rtl/ddr_refresh_rank.sv - per-rank interval timer, pending counter and overflow flag
// Optional pull-in credit enabled by DDR_REFRESH_PULLIN_EN.
module ddr_refresh_rank import ddr_refresh_pkg::*; #(
  parameter int RANK_IDX     = 0,
  parameter int NUM_RANKS    = 2,
  parameter int PERIOD_WIDTH = 10,
  parameter int PEND_WIDTH   = PEND_WIDTH_DEF,
  parameter int NEED_THRESH  = NEED_THRESH_DEF,
  parameter int MAX_PULLIN   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set,
  input  logic                    cry,
  input  logic                    en,
  input  logic                    grant,
`ifdef DDR_REFRESH_PULLIN_EN
  input  logic                    idle,
`endif
  input  logic [PERIOD_WIDTH-1:0] refresh_period,
  output logic                    want,
  output logic                    pend_want,
  output logic                    need,
  output logic                    overflow
);

  localparam int SHIFT = $clog2(NUM_RANKS);
  localparam logic [PEND_WIDTH-1:0] PEND_SAT = PEND_WIDTH'(pend_max(PEND_WIDTH));

  logic [PERIOD_WIDTH-1:0] cnt;
  logic [PERIOD_WIDTH-1:0] stagger;
  logic [PEND_WIDTH-1:0]   pending;
  logic                    over;
  logic                    due;
  logic                    use_credit;
  logic                    inc;
  logic                    dec;

  // Spread ranks evenly across one interval so their REFs do not bunch up.
  assign stagger = PERIOD_WIDTH'(RANK_IDX) * (refresh_period >> SHIFT);
  assign over    = (cnt == '0) && cry && en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      due <= 1'b0;
    end else if (set) begin
      cnt <= stagger;
      due <= 1'b0;
    end else begin
      due <= over;
      if (over)
        cnt <= refresh_period;
      else if (cry && en)
        cnt <= cnt - 1'b1;
    end
  end

  assign inc = due && !grant && !use_credit;
  assign dec = !due && grant && (pending != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else if (set) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else if (!en) begin
      pending <= '0;
    end else if (inc) begin
      if (pending == PEND_SAT)
        overflow <= 1'b1;
      else
        pending <= pending + 1'b1;
    end else if (dec) begin
      pending <= pending - 1'b1;
    end
  end

  assign need      = en && (pending >= PEND_WIDTH'(NEED_THRESH));
  assign pend_want = en && (pending != '0);

`ifdef DDR_REFRESH_PULLIN_EN
  localparam int CW = $clog2(MAX_PULLIN + 1);

  logic [CW-1:0] credit;
  logic          pull_want;

  assign use_credit = due && (credit != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      credit <= '0;
    else if (set || !en)
      credit <= '0;
    else if (grant && !due && (pending == '0) && (credit != CW'(MAX_PULLIN)))
      credit <= credit + 1'b1;
    else if (use_credit && !grant)
      credit <= credit - 1'b1;
  end

  assign pull_want = en && idle && (pending == '0) && (credit < CW'(MAX_PULLIN));
  assign want      = pend_want | pull_want;
`else
  localparam int unused_pullin_cap = MAX_PULLIN;

  assign use_credit = 1'b0;
  assign want       = pend_want;
`endif

endmodule

// File: rtl/ddr_refresh_sched.sv
// rtl/ddr_refresh_sched.sv - multi-rank refresh scheduler: prescaler, rank timers, round-robin select
// Optional pull-in credit enabled by DDR_REFRESH_PULLIN_EN.
module ddr_refresh_sched import ddr_refresh_pkg::*; #(
  parameter int NUM_RANKS    = 2,
  parameter int PERIOD_WIDTH = 10,
  parameter int PRE_DIV_BITS = 4,
  parameter int PEND_WIDTH   = PEND_WIDTH_DEF,
  parameter int NEED_THRESH  = NEED_THRESH_DEF,
  parameter int MAX_PULLIN   = 8
) (
  input logic                clk,
  input logic                rst,
  ddr_refresh_sched_if.slave bus
);

  localparam int RW = idx_width(NUM_RANKS);

  logic [PRE_DIV_BITS-1:0] pre_div;
  logic                    cry;
  logic [NUM_RANKS-1:0]    want;
  logic [NUM_RANKS-1:0]    pend_want;
  logic [NUM_RANKS-1:0]    need;
  logic [NUM_RANKS-1:0]    ovf;
  logic [NUM_RANKS-1:0]    cand;
  logic [RW-1:0]           rr_ptr;
  logic [RW-1:0]           rr_next;
  logic [RW-1:0]           sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_div <= '0;
      cry     <= 1'b0;
    end else if (bus.set) begin
      pre_div <= '0;
      cry     <= 1'b0;
    end else begin
      pre_div <= pre_div + 1'b1;
      cry     <= &pre_div;
    end
  end

  for (genvar r = 0; r < NUM_RANKS; r++) begin : g_rank
    ddr_refresh_rank #(
      .RANK_IDX     (r),
      .NUM_RANKS    (NUM_RANKS),
      .PERIOD_WIDTH (PERIOD_WIDTH),
      .PEND_WIDTH   (PEND_WIDTH),
      .NEED_THRESH  (NEED_THRESH),
      .MAX_PULLIN   (MAX_PULLIN)
    ) u_rank (
      .clk            (clk),
      .rst            (rst),
      .set            (bus.set),
      .cry            (cry),
      .en             (bus.rank_en[r]),
      .grant          (bus.grant[r]),
`ifdef DDR_REFRESH_PULLIN_EN
      .idle           (bus.idle),
`endif
      .refresh_period (bus.refresh_period),
      .want           (want[r]),
      .pend_want      (pend_want[r]),
      .need           (need[r]),
      .overflow       (ovf[r])
    );
  end

`ifndef DDR_REFRESH_PULLIN_EN
  logic unused_idle;
  assign unused_idle = bus.idle;
`endif

  // Priority classes: need, then real pending, then pull-in opportunity.
  always_comb begin
    cand = '0;
    sel  = '0;
    if (|need)
      cand = need;
    else if (|pend_want)
      cand = pend_want;
    else
      cand = want;
    for (int i = NUM_RANKS - 1; i >= 0; i--) begin
      if (cand[(int'(rr_ptr) + i) % NUM_RANKS])
        sel = RW'((int'(rr_ptr) + i) % NUM_RANKS);
    end
  end

  always_comb begin
    rr_next = rr_ptr;
    for (int i = 0; i < NUM_RANKS; i++) begin
      if (bus.grant[i])
        rr_next = RW'((i + 1) % NUM_RANKS);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (bus.set)
      rr_ptr <= '0;
    else
      rr_ptr <= rr_next;
  end

  assign bus.want      = want;
  assign bus.need      = need;
  assign bus.sel_valid = |want;
  assign bus.sel_rank  = sel;
  assign bus.overflow  = ovf;

endmodule

// File: tb/tb_ddr_refresh_sched.sv
// tb/tb_ddr_refresh_sched.sv - directed scoreboard bench for ddr_refresh_sched
module tb_ddr_refresh_sched;

  localparam int NR = 2;
  localparam int PW = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ddr_refresh_sched_if #(.NUM_RANKS(NR), .PERIOD_WIDTH(PW)) bus ();

  ddr_refresh_sched #(
    .NUM_RANKS    (NR),
    .PERIOD_WIDTH (PW),
    .PRE_DIV_BITS (4),
    .PEND_WIDTH   (5),
    .NEED_THRESH  (8),
    .MAX_PULLIN   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string          tag;
    logic [NR-1:0]  want;
    logic [NR-1:0]  need;
    logic           sel_valid;
    logic           sel_rank;
    logic [NR-1:0]  ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ecount = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic step_to(input int n);
    while (ecount < n) tick();
  endtask

  task automatic do_set();
    bus.set = 1'b1;
    tick();
    bus.set = 1'b0;
    ecount  = 0;
  endtask

  task automatic do_grant(input logic [NR-1:0] mask);
    bus.grant = mask;
    tick();
    bus.grant = '0;
  endtask

  task automatic expect_out(input string tag, input logic [NR-1:0] w, input logic [NR-1:0] n,
                            input logic s, input logic [NR-1:0] o);
    exp_t e;
    e.tag       = tag;
    e.want      = w;
    e.need      = n;
    e.sel_valid = |w;
    e.sel_rank  = s;
    e.ovf       = o;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
    end
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    assert (sb.size() != 0)
    else begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      cmp(e.tag, "want",      8'(bus.want),      8'(e.want));
      cmp(e.tag, "need",      8'(bus.need),      8'(e.need));
      cmp(e.tag, "sel_valid", 8'(bus.sel_valid), 8'(e.sel_valid));
      cmp(e.tag, "sel_rank",  8'(bus.sel_rank),  8'(e.sel_rank));
      cmp(e.tag, "overflow",  8'(bus.overflow),  8'(e.ovf));
    end
  endtask

  task automatic exp_at(input int n, input string tag, input logic [NR-1:0] w, input logic [NR-1:0] nd,
                        input logic s, input logic [NR-1:0] o);
    expect_out(tag, w, nd, s, o);
    step_to(n);
    check_out();
  endtask

  initial begin
    rst                = 1'b1;
    bus.set            = 1'b0;
    bus.rank_en        = '0;
    bus.idle           = 1'b0;
    bus.grant          = '0;
    bus.refresh_period = '0;
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 2'b00, 2'b00, 1'b0, 2'b00);
    check_out();
    rst = 1'b0;
    tick();

    // Period 3: rank0 due right after first cry, then every 64 clk.
    bus.refresh_period = 10'd3;
    bus.rank_en        = 2'b11;
    do_set();
    exp_at(17,  "p3_pre_due",  2'b00, 2'b00, 1'b0, 2'b00);
    exp_at(18,  "p3_r0_due1",  2'b01, 2'b00, 1'b0, 2'b00);
    exp_at(33,  "p3_r1_pre",   2'b01, 2'b00, 1'b0, 2'b00);
    exp_at(34,  "p3_r1_due1",  2'b11, 2'b00, 1'b0, 2'b00);
    exp_at(465, "p3_r0_7due",  2'b11, 2'b00, 1'b0, 2'b00);
    exp_at(466, "p3_r0_need",  2'b11, 2'b01, 1'b0, 2'b00);
    exp_at(481, "p3_r1_7due",  2'b11, 2'b01, 1'b0, 2'b00);
    exp_at(482, "p3_r1_need",  2'b11, 2'b11, 1'b0, 2'b00);

    // Stagger: rank1 trails rank0 by half the interval.
    bus.refresh_period = 10'd8;
    do_set();
    exp_at(17, "stg_pre",    2'b00, 2'b00, 1'b0, 2'b00);
    exp_at(18, "stg_r0",     2'b01, 2'b00, 1'b0, 2'b00);
    exp_at(81, "stg_r1_pre", 2'b01, 2'b00, 1'b0, 2'b00);
    exp_at(82, "stg_r1",     2'b11, 2'b00, 1'b0, 2'b00);

    // Grant handling on rank0 with a due on every cry.
    bus.refresh_period = 10'd0;
    bus.rank_en        = 2'b01;
    do_set();
    exp_at(34, "gr_pend2", 2'b01, 2'b00, 1'b0, 2'b00);
    step_to(49);
    expect_out("gr_coinc", 2'b01, 2'b00, 1'b0, 2'b00);
    do_grant(2'b01);
    check_out();
    expect_out("gr_to1", 2'b01, 2'b00, 1'b0, 2'b00);
    do_grant(2'b01);
    check_out();
    expect_out("gr_to0", 2'b00, 2'b00, 1'b0, 2'b00);
    do_grant(2'b01);
    check_out();
    expect_out("gr_at0", 2'b00, 2'b00, 1'b0, 2'b00);
    do_grant(2'b01);
    check_out();
    exp_at(65, "gr_idle", 2'b00, 2'b00, 1'b0, 2'b00);
`ifdef DDR_REFRESH_PULLIN_EN
    exp_at(66, "gr_next_due", 2'b00, 2'b00, 1'b0, 2'b00);
`else
    exp_at(66, "gr_next_due", 2'b01, 2'b00, 1'b0, 2'b00);
`endif

    // Saturation: 32 due events into a 5-bit pending counter.
    do_set();
    exp_at(498, "sat_31", 2'b01, 2'b01, 1'b0, 2'b00);
    bus.refresh_period = 10'd1023;
    exp_at(513, "sat_pre_ovf", 2'b01, 2'b01, 1'b0, 2'b00);
    exp_at(514, "sat_ovf",     2'b01, 2'b01, 1'b0, 2'b01);
    expect_out("sat_pend8", 2'b01, 2'b01, 1'b0, 2'b01);
    for (int i = 0; i < 23; i++) do_grant(2'b01);
    check_out();
    expect_out("sat_pend7", 2'b01, 2'b00, 1'b0, 2'b01);
    do_grant(2'b01);
    check_out();
    expect_out("sat_set_clr", 2'b00, 2'b00, 1'b0, 2'b00);
    do_set();
    check_out();

    // Arbitration: need priority, then round-robin alternation.
    bus.refresh_period = 10'd0;
    bus.rank_en        = 2'b11;
    do_set();
    step_to(135);
    bus.refresh_period = 10'd1023;
    exp_at(146, "arb_both9", 2'b11, 2'b11, 1'b0, 2'b00);
    for (int i = 0; i < 6; i++) do_grant(2'b01);
    expect_out("arb_need1", 2'b11, 2'b10, 1'b1, 2'b00);
    do_grant(2'b10);
    check_out();
    expect_out("arb_rr0", 2'b11, 2'b00, 1'b0, 2'b00);
    do_grant(2'b10);
    check_out();
    expect_out("arb_rr1", 2'b11, 2'b00, 1'b1, 2'b00);
    do_grant(2'b01);
    check_out();
    expect_out("arb_rr0b", 2'b11, 2'b00, 1'b0, 2'b00);
    do_grant(2'b10);
    check_out();
    expect_out("arb_rr1b", 2'b11, 2'b00, 1'b1, 2'b00);
    do_grant(2'b01);
    check_out();

    // Asynchronous reset with pending work outstanding.
    expect_out("async_rst", 2'b00, 2'b00, 1'b0, 2'b00);
    rst = 1'b1;
    #1;
    check_out();
    tick();
    rst = 1'b0;
    tick();

`ifdef DDR_REFRESH_PULLIN_EN
    // Pull-in: idle grants bank credit that absorbs later due events.
    bus.refresh_period = 10'd0;
    bus.rank_en        = 2'b01;
    bus.idle           = 1'b1;
    do_set();
    expect_out("pi_want", 2'b01, 2'b00, 1'b0, 2'b00);
    check_out();
    for (int i = 0; i < 7; i++) do_grant(2'b01);
    expect_out("pi_credit7", 2'b01, 2'b00, 1'b0, 2'b00);
    check_out();
    expect_out("pi_credit8", 2'b00, 2'b00, 1'b0, 2'b00);
    do_grant(2'b01);
    check_out();
    bus.idle = 1'b0;
    exp_at(130, "pi_absorbed", 2'b00, 2'b00, 1'b0, 2'b00);
    exp_at(146, "pi_real_due", 2'b01, 2'b00, 1'b0, 2'b00);
`endif

    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_refresh_sched.md
Name: ddr_refresh_sched

Overview:
- Multi-rank DDR3 refresh request scheduler with a common prescaler and per-rank refresh interval timers.
- Tracks postponed refreshes per rank and raises want/need flags per rank.
- Selects one rank for the command sequencer: urgent ranks first, round-robin within a priority class.
- Sits beside the command sequencer/arbiter; the sequencer issues REF to the selected rank and returns a one-cycle per-rank grant.

Parameters:
- NUM_RANKS, 2, number of ranks; power of two, 1..8.
- PERIOD_WIDTH, 10, width of refresh_period and of each interval counter.
- PRE_DIV_BITS, 4, prescaler width; one period tick = 2^PRE_DIV_BITS clk.
- PEND_WIDTH, 5, width of each pending-request counter; saturates at 2^PEND_WIDTH-1.
- NEED_THRESH, 8, pending count at or above which the rank's need is asserted.
- MAX_PULLIN, 8, maximum refreshes issued ahead per rank (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- refresh_period  in  PERIOD_WIDTH  interval in prescaler ticks; sampled at each reload.
- set  in  1  synchronous restart: clears prescaler, counters, pending and pointer, and applies stagger.
- rank_en  in  NUM_RANKS  per-rank enable.
- idle  in  1  sequencer idle hint; used only with the optional feature.
- grant  in  NUM_RANKS  one-cycle REF-issued pulse; at most one bit set per cycle.
- want  out  NUM_RANKS  pending != 0 (plus pull-in opportunity, see Optional Feature).
- need  out  NUM_RANKS  pending >= NEED_THRESH.
- sel_valid  out  1  any want bit set.
- sel_rank  out  $clog2(NUM_RANKS) (min 1)  rank to refresh next.
- overflow  out  NUM_RANKS  sticky: pending saturated while another due event arrived.

Behaviour:
- Reset: all registers 0. want, need, sel_valid, sel_rank and overflow are all 0.
- Prescaler: pre_div increments every clk. cry is a registered pulse, asserted the cycle after pre_div is all-ones. set clears both pre_div and cry.
- Interval counter, rank r:
  - On set, loads stagger value r*(refresh_period>>log2(NUM_RANKS)).
  - over_r = (cnt_r==0) && cry && rank_en[r]. On over_r, reload refresh_period; else on cry && rank_en[r], decrement.
  - due_r is over_r registered (one-cycle latency).
- Pending counter, rank r (priority order):
  - set or !rank_en[r]: clear to 0.
  - due && !grant: increment; at max, hold and set overflow[r].
  - !due && grant: decrement; a grant at 0 is ignored.
  - due && grant together: unchanged.
- overflow[r] clears only on rst or set.
- need/want are combinational from registered pending. rank_en low forces want[r]=need[r]=0 and freezes the interval counter.
- Arbitration (combinational from registered state):
  - Candidate set = need bits if any are set, else want bits.
  - sel_rank = first candidate at or after rr_ptr, wrapping.
  - On any grant, rr_ptr <= granted index + 1, modulo NUM_RANKS.
- Wrap-around: refresh_period=0 produces a due event on every cry.
- Reset mid-operation: takes effect immediately; no partial state survives.

Optional Feature:
- Macro: DDR_REFRESH_PULLIN_EN.
- Defined:
  - Each rank has a credit counter, 0..MAX_PULLIN.
  - A grant while pending==0 increments credit, saturating.
  - A due event while credit>0 decrements credit instead of incrementing pending.
  - want[r] is additionally asserted when idle && pending==0 && credit<MAX_PULLIN && rank_en[r]. Such ranks rank below ordinary want in arbitration.
  - Credit clears on set or !rank_en.
- Undefined: no credit logic; idle is unused; a grant at pending 0 is ignored.

Decomposition:
- Package ddr_refresh_pkg: rank index width function, NEED_THRESH default, pending saturation constant.
- One natural sub-module, ddr_refresh_rank: interval counter, pending counter, overflow and optional credit for one rank, instantiated NUM_RANKS times.
- The top level holds the prescaler and the round-robin arbiter.

Test Plan:
- Period and threshold: NUM_RANKS=2, refresh_period=3, set pulse, no grants.
  - Rank0 first due 1 cycle after the first cry; then every 64 clk.
  - need[0] rises after the 8th due event.
- Stagger: refresh_period=8.
  - Rank1 due events lag rank0 by 4 ticks (64 clk).
- Grant handling:
  - pending=2, grant coincident with due: stays 2.
  - Grant alone: 1; again: 0, want low.
  - Grant at 0: stays 0.
- Saturation: pending=31, due arrives.
  - Stays 31, overflow=1 until set.
- Arbitration: pending={rank0:3, rank1:9}.
  - sel_rank=1 (need priority).
  - After both pending <8, alternation 0,1,0 follows grants.
- Pull-in (macro defined): idle=1, pending=0.
  - want=1; 8 grants give credit=8, want drops.
  - Next 8 due events leave pending 0.
